// File: rtl/dedisp_channel_sum_pkg.sv
// Shared definitions for the dedispersor chain: frame FSM encoding,
// width helpers and default channel/sample sizes.
package dedisp_channel_sum_pkg;

  localparam int DEF_N_CHANNELS = 8;
  localparam int DEF_DIN_WIDTH  = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width that holds the sum of n_ch unsigned samples without overflow.
  function automatic int sum_width(input int din_w, input int n_ch);
    return din_w + clog2(n_ch);
  endfunction

endpackage

// File: rtl/dedisp_frame_checker.sv
// Frame framing FSM: tracks the channel position inside a frame and turns
// each accepted beat into exactly one of load/accum/commit strobes, plus an
// error strobe for any sof/eof violation. sof is decided before eof.
module dedisp_frame_checker
  import dedisp_channel_sum_pkg::*;
#(
  parameter int N_CHANNELS = DEF_N_CHANNELS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ce,
  input  logic i_valid,
  input  logic i_sof,
  input  logic i_eof,
  output logic o_load,
  output logic o_accum,
  output logic o_commit,
  output logic o_error,
  output logic o_state
);

  localparam int CNT_W = clog2(N_CHANNELS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHANNELS - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_chan_cnt;

  logic w_beat;
  logic w_last;
  logic w_load;
  logic w_accum;
  logic w_commit;
  logic w_error;

  assign w_beat = i_ce & i_valid;
  assign w_last = (r_chan_cnt == LAST_CNT);

  // Classify the current beat. A sof always (re)starts a frame unless it
  // also carries eof, which can never be a legal one-channel frame.
  always_comb begin
    w_load   = 1'b0;
    w_accum  = 1'b0;
    w_commit = 1'b0;
    w_error  = 1'b0;
    if (w_beat) begin
      if (i_sof) begin
        if (i_eof) begin
          w_error = 1'b1;
        end else begin
          w_load = 1'b1;
          if (r_state == ST_ACCUM) w_error = 1'b1;
        end
      end else if (r_state == ST_IDLE) begin
        w_error = 1'b1;
      end else if (i_eof) begin
        if (w_last) w_commit = 1'b1;
        else        w_error  = 1'b1;
      end else if (w_last) begin
        w_error = 1'b1;
      end else begin
        w_accum = 1'b1;
      end
    end
  end

  // Frame state and channel counter; every non-continuing outcome ends in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_chan_cnt <= '0;
    end else if (w_beat) begin
      if (w_load) begin
        r_state    <= ST_ACCUM;
        r_chan_cnt <= CNT_W'(1);
      end else if (w_accum) begin
        r_chan_cnt <= r_chan_cnt + CNT_W'(1);
      end else begin
        r_state    <= ST_IDLE;
        r_chan_cnt <= '0;
      end
    end
  end

  assign o_load   = w_load;
  assign o_accum  = w_accum;
  assign o_commit = w_commit;
  assign o_error  = w_error;
  assign o_state  = r_state;

endmodule

// File: rtl/dedisp_channel_sum.sv
// Sums each frame of N_CHANNELS dedispersed channels into one time sample,
// flags sums at or above a per-frame threshold and tags good frames with a
// running index. Malformed frames are dropped with a frame_err pulse.
// Handshake: a beat is consumed on every clock with ce=1 and din_valid=1;
// there is no backpressure, and dout_valid is a single-cycle qualifier.
module dedisp_channel_sum
  import dedisp_channel_sum_pkg::*;
#(
  parameter int N_CHANNELS = DEF_N_CHANNELS,
  parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int SUM_WIDTH  = sum_width(DIN_WIDTH, N_CHANNELS),
  parameter int FCNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic                  din_sof,
  input  logic                  din_eof,
  input  logic [SUM_WIDTH-1:0]  threshold,
  output logic [SUM_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic                  dout_detect,
  output logic [FCNT_WIDTH-1:0] dout_fcnt,
  output logic                  frame_err
);

  logic w_load;
  logic w_accum;
  logic w_commit;
  logic w_error;
  logic w_state;

  logic [SUM_WIDTH-1:0] w_din_ext;
  logic [SUM_WIDTH-1:0] w_sum;

  logic [SUM_WIDTH-1:0]  r_acc;
  logic [SUM_WIDTH-1:0]  r_thr;
  logic [FCNT_WIDTH-1:0] r_fcnt;
  logic [SUM_WIDTH-1:0]  r_dout;
  logic                  r_dout_valid;
  logic                  r_dout_detect;
  logic [FCNT_WIDTH-1:0] r_dout_fcnt;
  logic                  r_frame_err;

  dedisp_frame_checker #(
    .N_CHANNELS (N_CHANNELS)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ce     (ce),
    .i_valid  (din_valid),
    .i_sof    (din_sof),
    .i_eof    (din_eof),
    .o_load   (w_load),
    .o_accum  (w_accum),
    .o_commit (w_commit),
    .o_error  (w_error),
    .o_state  (w_state)
  );

  assign w_din_ext = {{(SUM_WIDTH-DIN_WIDTH){1'b0}}, din};
  assign w_sum     = r_acc + w_din_ext;

  // Accumulator, sampled threshold, frame index and registered outputs.
  // With ce low everything holds, so a pending pulse stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_thr         <= '0;
      r_fcnt        <= '0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_dout_detect <= 1'b0;
      r_dout_fcnt   <= '0;
      r_frame_err   <= 1'b0;
    end else if (ce) begin
      r_dout_valid  <= w_commit;
      r_dout_detect <= w_commit && (w_sum >= r_thr);
      r_frame_err   <= w_error;
      if (w_load) begin
        r_acc <= w_din_ext;
        r_thr <= threshold;
      end else if (w_accum) begin
        r_acc <= w_sum;
      end
      if (w_commit) begin
        r_dout      <= w_sum;
        r_dout_fcnt <= r_fcnt;
        r_fcnt      <= r_fcnt + FCNT_WIDTH'(1);
      end
    end
  end

  // A frame can only complete while one is open.
  a_commit_in_frame: assert property (@(posedge clk) disable iff (!rst_n)
    w_commit |-> (w_state == ST_ACCUM));

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign dout_detect = r_dout_detect;
  assign dout_fcnt   = r_dout_fcnt;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_dedisp_channel_sum.sv
// Directed bench for dedisp_channel_sum (N=8, 32-bit samples, 35-bit sums).
// Stimulus pushes the hand-computed result of each good frame into exp_q;
// a negedge monitor pops and compares whenever dout_valid is seen.
module tb_dedisp_channel_sum;

  localparam int SW = 35;
  localparam int FW = 32;
  localparam int EW = 1 + FW + SW;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic [31:0]   din;
  logic          din_valid;
  logic          din_sof;
  logic          din_eof;
  logic [SW-1:0] threshold;
  logic [SW-1:0] dout;
  logic          dout_valid;
  logic          dout_detect;
  logic [FW-1:0] dout_fcnt;
  logic          frame_err;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int exp_err  = 0;

  dedisp_channel_sum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .din         (din),
    .din_valid   (din_valid),
    .din_sof     (din_sof),
    .din_eof     (din_eof),
    .threshold   (threshold),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_detect (dout_detect),
    .dout_fcnt   (dout_fcnt),
    .frame_err   (frame_err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge.
  task automatic beat(input logic [31:0] d, input logic s, input logic e);
    din       = d;
    din_sof   = s;
    din_eof   = e;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    din_eof   = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input logic det, input logic [FW-1:0] fcnt, input logic [SW-1:0] sum);
    exp_q.push_back({det, fcnt, sum});
  endtask

  task automatic chk_err(input string name);
    gap(2);
    chk(name, EW'(err_seen), EW'(exp_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gap(2);
    chk("rst_dout", EW'(dout), '0);
    chk("rst_dout_valid", EW'(dout_valid), '0);
    chk("rst_dout_detect", EW'(dout_detect), '0);
    chk("rst_dout_fcnt", EW'(dout_fcnt), '0);
    chk("rst_frame_err", EW'(frame_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_dout_valid: got dout=%0h fcnt=%0d with nothing expected (t=%0t)",
                   dout, dout_fcnt, $time);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("dout", EW'(dout), EW'(e[SW-1:0]));
          chk("dout_fcnt", EW'(dout_fcnt), EW'(e[SW+FW-1:SW]));
          chk("dout_detect", EW'(dout_detect), EW'(e[EW-1]));
        end
      end else begin
        chk("detect_idle", EW'(dout_detect), '0);
      end
      if (frame_err) err_seen++;
    end
  end

  initial begin
    rst_n     = 1'b0;
    ce        = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    din_eof   = 1'b0;
    threshold = '0;
    #12;
    do_reset();

    // 1: frame 1..8, threshold 30 -> 36, detect, index 0, one cycle after eof
    threshold = 35'd30;
    expect_frame(1'b1, 32'd0, 35'd36);
    for (int i = 1; i <= 8; i++) beat(32'(i), i == 1, i == 8);
    chk("t1_latency", EW'(dout_valid), EW'(1));
    chk_err("t1_no_err");

    // 2: two back-to-back all-ones frames; threshold just above the max sum
    do_reset();
    threshold = 35'h7_FFFF_FFFF;
    expect_frame(1'b0, 32'd0, 35'h7_FFFF_FFF8);
    expect_frame(1'b0, 32'd1, 35'h7_FFFF_FFF8);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) beat(32'hFFFF_FFFF, i == 0, i == 7);
    chk_err("t2_no_err");

    // 3: short frame of 5, then frame of 2s -> 16, index 0
    do_reset();
    threshold = 35'd0;
    for (int i = 0; i < 5; i++) beat(32'd9, i == 0, i == 4);
    exp_err++;
    chk("t3_err_pulse", EW'(frame_err), EW'(1));
    expect_frame(1'b1, 32'd0, 35'd16);
    for (int i = 0; i < 8; i++) beat(32'd2, i == 0, i == 7);
    chk_err("t3_err_count");

    // 4: 4 beats then restart; new threshold 8 sampled on restart; random gaps
    do_reset();
    threshold = 35'd100;
    for (int i = 0; i < 4; i++) beat(32'd50, i == 0, 1'b0);
    threshold = 35'd8;
    exp_err++;
    expect_frame(1'b1, 32'd0, 35'd8);
    for (int i = 0; i < 8; i++) begin
      beat(32'd1, i == 0, i == 7);
      if (i == 3) threshold = 35'd1000;
      if (i < 7) gap($urandom_range(0, 3));
    end
    chk_err("t4_err_count");

    // 5: asynchronous reset mid-frame clears outputs and the frame index
    do_reset();
    threshold = 35'd0;
    expect_frame(1'b1, 32'd0, 35'd36);
    for (int i = 1; i <= 8; i++) beat(32'(i), i == 1, i == 8);
    gap(2);
    for (int i = 0; i < 3; i++) beat(32'd1, i == 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_dout", EW'(dout), '0);
    chk("t5_async_fcnt", EW'(dout_fcnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    threshold = 35'd9;
    expect_frame(1'b0, 32'd0, 35'd8);
    for (int i = 0; i < 8; i++) beat(32'd1, i == 0, i == 7);
    chk_err("t5_err_count");

    // 6: ce low for 3 cycles mid-frame; beats offered then are ignored
    do_reset();
    threshold = 35'd8;
    expect_frame(1'b1, 32'd0, 35'd8);
    for (int i = 0; i < 3; i++) beat(32'd1, i == 0, 1'b0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din       = 32'd100;
      din_valid = (i != 1);
      din_sof   = (i == 2);
      din_eof   = (i == 0);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    din_sof   = 1'b0;
    din_eof   = 1'b0;
    ce        = 1'b1;
    for (int i = 0; i < 5; i++) beat(32'd1, 1'b0, i == 4);
    chk_err("t6_err_count");

    // 7: framing corner cases, then a good frame still indexed 0
    do_reset();
    beat(32'd5, 1'b1, 1'b1);                                  // sof+eof from IDLE
    beat(32'd5, 1'b0, 1'b0);                                  // stray beat
    for (int i = 0; i < 8; i++) beat(32'd3, i == 0, 1'b0);    // missing eof
    beat(32'd1, 1'b1, 1'b0);
    beat(32'd1, 1'b1, 1'b1);                                  // sof+eof mid-frame
    beat(32'd1, 1'b0, 1'b0);                                  // proves state is IDLE
    exp_err += 5;
    chk_err("t7_err_count");
    threshold = 35'd37;
    expect_frame(1'b0, 32'd0, 35'd36);
    for (int i = 1; i <= 8; i++) beat(32'(i), i == 1, i == 8);
    chk_err("t7_final_err_count");

    gap(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected frames never appeared", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
